// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: a single multiply-accumulate unit walks all IPD taps of a
// circular delay line, producing one unsigned, OPL-bit truncated result per accepted sample.
module fir_mac_sequencer #(
    parameter int IPL = 4,
    parameter int CEL = 4,
    parameter int OPL = 6,
    parameter int IPD = 4,
    localparam int TW = $clog2(IPD)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IPL-1:0] x_in,
    input  logic           x_valid,
    output logic           x_ready,
    input  logic           c_wr,
    input  logic [TW-1:0]  c_addr,
    input  logic [CEL-1:0] c_data,
    output logic           c_err,
    output logic [OPL-1:0] y_out,
    output logic           y_valid,
    output logic           busy
);

    typedef enum logic {IDLE, MAC} state_t;

    state_t         state_reg;
    logic [IPL-1:0] line_reg [IPD];
    logic [CEL-1:0] coef_reg [IPD];
    logic [TW-1:0]  wp_reg;
    logic [TW-1:0]  wp_cur_reg;
    logic [TW-1:0]  k_reg;
    logic [OPL-1:0] acc_reg;
    logic [OPL-1:0] y_out_reg;
    logic           y_valid_reg;
    logic           c_err_reg;

    logic           accept;
    logic           addr_ok;
    logic           coef_wr_ok;
    logic [TW-1:0]  wp_next;
    logic [TW-1:0]  tap_idx;
    logic [IPL+CEL-1:0] prod;
    logic [OPL-1:0] acc_next;
    logic [IPD-1:0] coef_we;
    logic [IPD-1:0] line_we;

    assign x_ready    = (state_reg == IDLE) && !rst;
    assign accept     = x_valid && x_ready;
    assign addr_ok    = int'(c_addr) < IPD;
    assign coef_wr_ok = c_wr && addr_ok && (state_reg == IDLE);
    assign wp_next    = (wp_reg == TW'(IPD - 1)) ? '0 : wp_reg + TW'(1);

    // Per-slot write enables for the coefficient bank and the delay line.
    genvar gi;
    generate
        for (gi = 0; gi < IPD; gi++) begin : g_we
            assign coef_we[gi] = coef_wr_ok && (c_addr == TW'(gi));
            assign line_we[gi] = accept && (wp_reg == TW'(gi));
        end
    endgenerate

    // Tap k looks back k slots from the newest sample; wrap explicitly so
    // non-power-of-2 depths index correctly.
    always_comb begin
        tap_idx = '0;
        if (wp_cur_reg >= k_reg)
            tap_idx = wp_cur_reg - k_reg;
        else
            tap_idx = TW'(int'(wp_cur_reg) + IPD - int'(k_reg));
    end

    assign prod     = {{IPL{1'b0}}, coef_reg[k_reg]} * {{CEL{1'b0}}, line_reg[tap_idx]};
    assign acc_next = acc_reg + OPL'(prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            wp_reg      <= '0;
            wp_cur_reg  <= '0;
            k_reg       <= '0;
            acc_reg     <= '0;
            y_out_reg   <= '0;
            y_valid_reg <= 1'b0;
            c_err_reg   <= 1'b0;
            for (int i = 0; i < IPD; i++) begin
                line_reg[i] <= '0;
                coef_reg[i] <= '0;
            end
        end else begin
            y_valid_reg <= 1'b0;
            c_err_reg   <= c_wr && !coef_wr_ok;
            for (int i = 0; i < IPD; i++) begin
                if (coef_we[i])
                    coef_reg[i] <= c_data;
                if (line_we[i])
                    line_reg[i] <= x_in;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        wp_cur_reg <= wp_reg;
                        wp_reg     <= wp_next;
                        acc_reg    <= '0;
                        k_reg      <= '0;
                        state_reg  <= MAC;
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    if (k_reg == TW'(IPD - 1)) begin
                        y_out_reg   <= acc_next;
                        y_valid_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        k_reg <= k_reg + TW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign y_out   = y_out_reg;
    assign y_valid = y_valid_reg;
    assign c_err   = c_err_reg;
    assign busy    = (state_reg == MAC);

endmodule
